photocell_conditioner: RTL and testbench
========================================

# photocell_conditioner

Input conditioning stage for the smart bank queue manager. Takes the two raw, asynchronous beam-break sensors (rear/entry and front/exit) and synchronizes and debounces them. It converts beam-break edges into the single-cycle 2-bit `PHOTOCELL` event code consumed by the queue control unit. It also flags sensors whose beam stays broken too long (blocked or failed sensor) so the display logic can report a fault.

## Interface

Parameters:
- `DEBOUNCE`, default 4: consecutive stable cycles required before a debounced level changes; must be ≥ 1.
- `STUCK_CYCLES`, default 1000: cycles of continuous debounced "broken" before the stuck flag sets; must be > `DEBOUNCE`.

Ports:
- `CLK`, input, 1: the single clock; all state on its rising edge.
- `RESET`, input, 1: asynchronous, active-low reset (0 = reset).
- `BEAM_REAR`, input, 1: raw rear (entry) sensor, asynchronous; 1 = beam broken.
- `BEAM_FRONT`, input, 1: raw front (exit) sensor, asynchronous; 1 = beam broken.
- `PHOTOCELL`, output, 2: registered event code, one cycle wide.
  - 2'b00 = no event.
  - 2'b01 = customer entered (rear edge).
  - 2'b10 = customer left (front edge).
  - Never 2'b11.
- `BEAM_STATE`, output, 2: debounced levels, {front, rear}.
- `STUCK`, output, 2: per-channel stuck-beam flags, {front, rear}.

## Operation

- Per channel, a 2-flop synchronizer is followed by a debouncer.
- Debouncer:
  - Holds a debounced level and a counter of width ceil(log2(DEBOUNCE+1)).
  - When the synchronized value differs from the debounced level, the counter increments; otherwise it clears to 0.
  - When the counter reaches `DEBOUNCE`, the debounced level takes the synchronized value and the counter clears.
  - A glitch shorter than `DEBOUNCE` cycles produces no level change.
- Event detect: a 0→1 transition of a debounced level sets that channel's pending bit. A 1→0 transition produces no event.
- Event emitter:
  - Each cycle, `PHOTOCELL` is registered from the pending bits with priority front > rear.
  - If the front bit is pending, emit 2'b10 and clear it.
  - Otherwise, if the rear bit is pending, emit 2'b01 and clear it.
  - Otherwise, emit 2'b00.
- Simultaneous edges on both channels in the same cycle: 2'b10 in the first output cycle, 2'b01 in the next. No event is lost.
- Exit has priority so a full queue can accept the entry that arrives with it.
- Pending bits cannot overrun: debounced edges on one channel are at least 2·DEBOUNCE cycles apart, and a pending bit waits at most 1 cycle.
- Stuck detect:
  - Per channel, a saturating counter of width ceil(log2(STUCK_CYCLES+1)) increments while the debounced level is 1 and clears when it is 0.
  - `STUCK` sets when the count reaches `STUCK_CYCLES` and stays set while the level remains 1.
  - `STUCK` clears in the same cycle the debounced level returns to 0.
- Stuck state does not suppress the entry event, which has already been emitted on the original edge.
- Reset (RESET = 0, asynchronous) clears everything:
  - All registers clear: synchronizers, debounced levels, counters, pending bits.
  - Outputs go to `PHOTOCELL` = 2'b00, `BEAM_STATE` = 2'b00, `STUCK` = 2'b00.
- Reset mid-operation:
  - Any pending event is discarded.
  - On release, a beam already broken is seen as a new 0→1 edge after debounce and emits one event.

## Timing

- A raw input changes and is held stable before rising edge N:
  - The synchronized value reflects it at edge N+1.
  - The debounced level (`BEAM_STATE`) changes at edge N+1+DEBOUNCE.
  - `PHOTOCELL` is valid for exactly one cycle after edge N+2+DEBOUNCE.
- Rear-only latency is 2+DEBOUNCE cycles. With default `DEBOUNCE` = 4, the pulse follows 6 cycles after the raw edge.
- Simultaneous both-channel edges:
  - The front event appears with the same 2+DEBOUNCE latency.
  - The rear event appears one cycle later.
- `STUCK` rises at edge N+1+DEBOUNCE+STUCK_CYCLES for a beam broken continuously from edge N.
- `STUCK` falls together with `BEAM_STATE`, DEBOUNCE+1 cycles after the raw release.
- Reset is asynchronous assert. The first capture occurs on the first rising edge with RESET = 1.

## Test plan

Bench parameters: `DEBOUNCE` = 4, `STUCK_CYCLES` = 16.

1. Reset: hold RESET = 0 with both beams at 1 → all outputs 0. Release → exactly one 2'b10 pulse, then one 2'b01 pulse, 6 and 7 cycles after release.
2. Clean entry: `BEAM_REAR` 0→1 for 10 cycles then 0 → `PHOTOCELL` = 2'b01 for exactly 1 cycle, 6 cycles after the rise. `BEAM_STATE[0]` is high for 10 cycles. No event on release.
3. Glitch rejection: `BEAM_FRONT` pulses of 1, 2 and 3 cycles separated by 5 low cycles → `PHOTOCELL` stays 2'b00 and `BEAM_STATE` stays 0 throughout.
4. Simultaneous edges: both beams 0→1 on the same edge → 2'b10 at cycle 6, 2'b01 at cycle 7, 2'b00 otherwise.
5. Stuck beam: `BEAM_REAR` held at 1 for 40 cycles → one 2'b01 event. `STUCK[0]` rises 21 cycles after the rise. `STUCK[0]` and `BEAM_STATE[0]` fall 5 cycles after release.
6. Reset mid-operation: `BEAM_FRONT` rises, then RESET pulses low 3 cycles later while the beam stays 1 → no pulse before reset. After release, exactly one 2'b10 pulse 6 cycles later.

Source files
------------

// File: rtl/photocell_conditioner.sv
// Beam-break sensor front end: two-flop synchronizers, debouncers, a prioritised
// one-cycle event emitter (exit before entry) and per-channel stuck-beam flags.
module photocell_conditioner #(
    parameter int DEBOUNCE     = 4,
    parameter int STUCK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BEAM_REAR,
    input  logic       BEAM_FRONT,
    output logic [1:0] PHOTOCELL,
    output logic [1:0] BEAM_STATE,
    output logic [1:0] STUCK
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_CYCLES);

    function automatic logic [ST_W-1:0] sat_inc(input logic [ST_W-1:0] v);
        return (v == ST_MAX) ? v : v + 1'b1;
    endfunction

    logic [1:0] raw;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] level;
    logic [1:0] level_next;
    logic [1:0] rise;
    logic [1:0] pending;
    logic [1:0] take;
    logic [1:0] stuck_hit;

    assign raw = {BEAM_FRONT, BEAM_REAR};

    // Stage: synchronizer, raw -> sync_p0 -> sync_p1
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [DB_W-1:0] db_cnt;
        logic [ST_W-1:0] st_cnt;
        logic            differ;
        logic            settle;

        // The level flips on the cycle the counter would reach DEBOUNCE.
        assign differ         = sync_p1[ch] != level[ch];
        assign settle         = differ && (db_cnt == DB_LAST);
        assign level_next[ch] = settle ? sync_p1[ch] : level[ch];
        assign rise[ch]       = settle && sync_p1[ch];
        assign stuck_hit[ch]  = level[ch] && (st_cnt == ST_MAX);

        // Stage: debounce and stuck counters
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                db_cnt <= '0;
                st_cnt <= '0;
            end else begin
                db_cnt <= (differ && !settle) ? db_cnt + 1'b1 : '0;
                st_cnt <= level[ch] ? sat_inc(st_cnt) : '0;
            end
        end
    end

    // Exit wins so a full queue can still take the entry that comes with it.
    always_comb begin
        take = 2'b00;
        if (pending[1]) begin
            take = 2'b10;
        end else if (pending[0]) begin
            take = 2'b01;
        end
    end

    // Stage: debounced level, pending events, registered event code
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            level     <= '0;
            pending   <= '0;
            PHOTOCELL <= '0;
        end else begin
            level     <= level_next;
            pending   <= (pending & ~take) | rise;
            PHOTOCELL <= take;
        end
    end

    assign BEAM_STATE = level;
    assign STUCK      = stuck_hit;
endmodule

// File: tb/tb_photocell_conditioner.sv
// Bench for photocell_conditioner: vector table, directed corner sequences and a
// randomized run against a window/timestamp based reference model.
`timescale 1ns/1ps
module tb_photocell_conditioner;
  localparam int D  = 4;
  localparam int SC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       beam_rear;
  logic       beam_front;
  logic [1:0] photocell;
  logic [1:0] beam_state;
  logic [1:0] stuck;

  int n_cmp  = 0;
  int n_fail = 0;

  photocell_conditioner #(.DEBOUNCE(D), .STUCK_CYCLES(SC)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .BEAM_REAR (beam_rear),
    .BEAM_FRONT(beam_front),
    .PHOTOCELL (photocell),
    .BEAM_STATE(beam_state),
    .STUCK     (stuck)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample history, window debounce, rise timestamps.
  bit         hist [2][D+2];
  bit         lvl [2];
  bit         pend [2];
  int         rise_t [2];
  int         t;
  logic [1:0] m_pc, m_bs, m_sk;

  logic [1:0] pc_log [64];
  logic [1:0] bs_log [64];
  logic [1:0] sk_log [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < D + 2; k++) hist[c][k] = 1'b0;
      lvl[c] = 1'b0; pend[c] = 1'b0; rise_t[c] = 0;
    end
    t = 0; m_pc = 2'b00; m_bs = 2'b00; m_sk = 2'b00;
  endtask

  // One rising edge. Debounced level at edge t follows the raw samples taken at
  // edges t-2 .. t-1-D: it flips when all D of them disagree with it.
  task automatic model_step(input bit r, input bit f);
    bit raw [2];
    bit all_diff;
    raw[0] = r; raw[1] = f;
    t++;
    for (int c = 0; c < 2; c++) begin
      for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raw[c];
    end
    if (pend[1]) begin m_pc = 2'b10; pend[1] = 1'b0; end
    else if (pend[0]) begin m_pc = 2'b01; pend[0] = 1'b0; end
    else m_pc = 2'b00;
    for (int c = 0; c < 2; c++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (hist[c][k] == lvl[c]) all_diff = 1'b0;
      if (all_diff) begin
        lvl[c] = !lvl[c];
        if (lvl[c]) begin pend[c] = 1'b1; rise_t[c] = t; end
      end
      m_bs[c] = lvl[c];
      m_sk[c] = lvl[c] && (t - rise_t[c] >= SC);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next fall.
  task automatic cyc(input bit r, input bit f, input bit rs, input int idx);
    beam_rear = r; beam_front = f; rst = rs;
    if (!rs) model_reset();
    @(posedge clk);
    if (rs) model_step(r, f);
    @(negedge clk);
    check("model_photocell", 32'(photocell), 32'(m_pc));
    check("model_beam_state", 32'(beam_state), 32'(m_bs));
    check("model_stuck", 32'(stuck), 32'(m_sk));
    if (idx >= 0 && idx < 64) begin
      pc_log[idx] = photocell; bs_log[idx] = beam_state; sk_log[idx] = stuck;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, -1);
  endtask

  typedef struct {
    int r_s; int r_l; int f_s; int f_l;
    int exp_r; int exp_f; int hi_r; int hi_f;
  } vec_t;

  initial begin
    vec_t vecs [9];
    bit   r, f;
    int   rs_hold, rate, hi_r, hi_f;
    logic [1:0] exp_pc;

    vecs[0] = '{0, 10, 0, 0,  6, -1, 10,  0};
    vecs[1] = '{0,  0, 0, 3, -1, -1,  0,  0};
    vecs[2] = '{0,  0, 0, 4, -1,  6,  0,  4};
    vecs[3] = '{0,  8, 0, 8,  7,  6,  8,  8};
    vecs[4] = '{0,  8, 1, 8,  6,  7,  8,  8};
    vecs[5] = '{1,  8, 0, 8,  7,  6,  8,  8};
    vecs[6] = '{0,  2, 3, 1, -1, -1,  0,  0};
    vecs[7] = '{0,  4, 0, 10, 7,  6,  4, 10};
    vecs[8] = '{0,  3, 0, 5, -1,  6,  0,  5};

    // Reset held with both beams broken, then release.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, -1);
      check("reset_photocell", 32'(photocell), 32'd0);
      check("reset_beam_state", 32'(beam_state), 32'd0);
      check("reset_stuck", 32'(stuck), 32'd0);
    end
    for (int j = 0; j < 12; j++) cyc(1'b1, 1'b1, 1'b1, j);
    for (int j = 0; j < 12; j++)
      check($sformatf("release_pc_j%0d", j), 32'(pc_log[j]),
            (j == 6) ? 32'd2 : (j == 7) ? 32'd1 : 32'd0);
    idle(20);

    // Vector table: pulse shapes with expected event cycles and high durations.
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 32; j++)
        cyc(bit'(j >= vecs[i].r_s && j < vecs[i].r_s + vecs[i].r_l),
            bit'(j >= vecs[i].f_s && j < vecs[i].f_s + vecs[i].f_l), 1'b1, j);
      hi_r = 0; hi_f = 0;
      for (int j = 0; j < 32; j++) begin
        exp_pc = (j == vecs[i].exp_f) ? 2'b10 : (j == vecs[i].exp_r) ? 2'b01 : 2'b00;
        check($sformatf("vec%0d_pc_j%0d", i, j), 32'(pc_log[j]), 32'(exp_pc));
        hi_r += int'(bs_log[j][0]);
        hi_f += int'(bs_log[j][1]);
      end
      check($sformatf("vec%0d_rear_hi", i), 32'(hi_r), 32'(vecs[i].hi_r));
      check($sformatf("vec%0d_front_hi", i), 32'(hi_f), 32'(vecs[i].hi_f));
    end

    // Front glitches of 1, 2 and 3 cycles, each followed by 5 low cycles.
    for (int p = 1; p <= 3; p++) begin
      for (int k = 0; k < p + 5; k++) begin
        cyc(1'b0, bit'(k < p), 1'b1, -1);
        check("glitch_photocell", 32'(photocell), 32'd0);
        check("glitch_beam_state", 32'(beam_state), 32'd0);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b1, -1);
      check("glitch_photocell", 32'(photocell), 32'd0);
      check("glitch_beam_state", 32'(beam_state), 32'd0);
    end

    // Rear held broken for 40 cycles.
    for (int j = 0; j < 60; j++) cyc(bit'(j < 40), 1'b0, 1'b1, j);
    for (int j = 0; j < 60; j++) begin
      check($sformatf("stuck_pc_j%0d", j), 32'(pc_log[j]), (j == 6) ? 32'd1 : 32'd0);
      check($sformatf("stuck_bs_j%0d", j), 32'(bs_log[j][0]), 32'(j >= 5 && j <= 44));
      check($sformatf("stuck_flag_j%0d", j), 32'(sk_log[j][0]), 32'(j >= 21 && j <= 44));
    end
    idle(10);

    // Reset three cycles into a front break; beam stays broken across it.
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, 1'b1, j);
    for (int j = 0; j < 3; j++) check("midreset_pre_pc", 32'(pc_log[j]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 1'b0, -1);
      check("midreset_photocell", 32'(photocell), 32'd0);
      check("midreset_beam_state", 32'(beam_state), 32'd0);
    end
    for (int j = 0; j < 12; j++) cyc(1'b0, 1'b1, 1'b1, j);
    for (int j = 0; j < 12; j++)
      check($sformatf("midreset_pc_j%0d", j), 32'(pc_log[j]), (j == 6) ? 32'd2 : 32'd0);
    idle(20);

    // Reset while both events are pending: both are discarded.
    for (int j = 0; j < 6; j++) cyc(1'b1, 1'b1, 1'b1, j);
    check("discard_pre_pc", 32'(pc_log[5]), 32'd0);
    check("discard_pre_bs", 32'(bs_log[5]), 32'd3);
    cyc(1'b1, 1'b1, 1'b0, -1);
    check("discard_reset_pc", 32'(photocell), 32'd0);
    for (int j = 0; j < 12; j++) cyc(1'b0, 1'b0, 1'b1, j);
    for (int j = 0; j < 12; j++) check("discard_post_pc", 32'(pc_log[j]), 32'd0);

    // Randomized run with mixed toggle rates and occasional resets.
    r = 1'b0; f = 1'b0; rs_hold = 0;
    for (int seg = 0; seg < 40; seg++) begin
      rate = (seg % 3 == 0) ? 3 : (seg % 3 == 1) ? 8 : 30;
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(rate - 1) == 0) r = !r;
        if ($urandom_range(rate - 1) == 0) f = !f;
        if (rs_hold == 0 && $urandom_range(299) == 0) rs_hold = $urandom_range(3, 1);
        cyc(r, f, rs_hold == 0, -1);
        if (rs_hold > 0) rs_hold--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
